// File: rtl/uart_autobaud_detector.sv
// uart_autobaud_detector: times the 0x55 sync character on UxRX against BRGCLK and loads the bit-period divisor.
// Define UART_ABD_ROUND_EN for a round-to-nearest divisor; otherwise the divisor is truncated.
module uart_autobaud_detector #(
    parameter int          CNT_W      = 16,
    parameter int          SYNC_FALLS = 4,
    parameter logic [15:0] RESET_DIV  = 16'd104
) (
    input  logic             BRGCLK,
    input  logic             rst_n,
    input  logic             ABAUD,
    input  logic             UxRX,
    output logic [CNT_W-1:0] brg_div,
    output logic [CNT_W-1:0] span,
    output logic             abd_busy,
    output logic             UxRXIF,
    output logic             ABDOVF
);
    localparam int SH = $clog2(SYNC_FALLS) + 1;
    localparam int FW = $clog2(SYNC_FALLS + 1);

    typedef enum logic [2:0] {IDLE, WAIT_IDLE, WAIT_START, MEASURE, DONE} state_t;

    state_t           state, state_d;
    logic             rx_m, rx_s, rx_s_q, fall;
    logic [CNT_W-1:0] cnt;
    logic [FW-1:0]    falls;
    logic [CNT_W:0]   cnt_inc;
    logic [CNT_W+1:0] div_sum;
    logic             complete, ovf, busy_d, if_d;

    assign fall     = rx_s_q & ~rx_s;
    assign cnt_inc  = {1'b0, cnt} + (CNT_W+1)'(1);
    assign complete = (state == MEASURE) && fall && (falls == FW'(SYNC_FALLS - 1));
    // abort outranks overflow, so a dropped ABAUD never raises the flag
    assign ovf      = (state == MEASURE) && (&cnt) && !complete && ABAUD;
`ifdef UART_ABD_ROUND_EN
    assign div_sum  = {1'b0, cnt_inc} + (CNT_W+2)'(SYNC_FALLS);
`else
    assign div_sum  = {1'b0, cnt_inc};
`endif

    always_ff @(posedge BRGCLK or negedge rst_n) begin
        if (!rst_n) {rx_m, rx_s, rx_s_q} <= 3'b111;
        else        {rx_m, rx_s, rx_s_q} <= {UxRX, rx_m, rx_s};
    end

    always_ff @(posedge BRGCLK or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:       state_d = ABAUD ? WAIT_IDLE : IDLE;
            WAIT_IDLE:  state_d = !ABAUD ? IDLE : rx_s ? WAIT_START : WAIT_IDLE;
            WAIT_START: state_d = !ABAUD ? IDLE : fall ? MEASURE : WAIT_START;
            MEASURE:    state_d = complete ? DONE : (!ABAUD || &cnt) ? IDLE : MEASURE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_d = (state_d == WAIT_IDLE) || (state_d == WAIT_START) || (state_d == MEASURE);
        if_d   = (state_d == DONE);
    end

    always_ff @(posedge BRGCLK or negedge rst_n) begin
        if (!rst_n) begin
            abd_busy <= 1'b0;
            UxRXIF   <= 1'b0;
            ABDOVF   <= 1'b0;
            cnt      <= '0;
            falls    <= '0;
            span     <= '0;
            brg_div  <= CNT_W'(RESET_DIV);
        end else begin
            abd_busy <= busy_d;
            UxRXIF   <= if_d;
            ABDOVF   <= (state == IDLE && ABAUD) ? 1'b0 : (ovf ? 1'b1 : ABDOVF);
            cnt      <= (state == MEASURE) ? cnt_inc[CNT_W-1:0] : '0;
            falls    <= (state == MEASURE) ? falls + FW'(fall) : '0;
            span     <= complete ? cnt_inc[CNT_W-1:0] : span;
            brg_div  <= complete ? CNT_W'(div_sum >> SH) : brg_div;
        end
    end
endmodule

// File: doc/uart_autobaud_detector.md
# uart_autobaud_detector

Parametrised auto-baud measurement block for the UART receive path. It times the 0x55 sync character on the receive line against BRGCLK and loads a rounded bit-period divisor into the baud-rate generator. It generalises the fixed 4-bit, fixed-pattern controller with configurable counter width, edge count, overflow detection, abort and a synchroniser.

## Interface
Parameters:
- CNT_W, 16: width of the span counter and the divisor output.
- SYNC_FALLS, 4: falling edges counted after the start-bit edge. Must be a power of two ≥1. The measured span is 2*SYNC_FALLS bit times.
- RESET_DIV, 16'd104: value of `brg_div` after reset.

Ports:
- BRGCLK  in  1  sole clock, rising edge.
- rst_n  in  1  reset. Asynchronous assert, active-low.
- ABAUD  in  1  level request. 1 = arm the measurement; dropping it to 0 aborts.
- UxRX  in  1  raw receive line, asynchronous to BRGCLK.
- brg_div  out  CNT_W  measured bit period in BRGCLK cycles.
- span  out  CNT_W  raw cycle count of the last successful measurement.
- abd_busy  out  1  high in WAIT_IDLE, WAIT_START and MEASURE.
- UxRXIF  out  1  one-cycle pulse when a measurement completes.
- ABDOVF  out  1  sticky overflow flag, cleared on the next arm.

## Operation
- UxRX passes through a 2-flop synchroniser into `rx_s`. A falling edge `fall` is `rx_s_q & ~rx_s`.
- States: IDLE, WAIT_IDLE, WAIT_START, MEASURE, DONE.
- Transitions:
  - IDLE → WAIT_IDLE when ABAUD=1. This clears ABDOVF.
  - WAIT_IDLE → WAIT_START when rx_s=1. This rejects a line that is already low.
  - WAIT_START → MEASURE on `fall`. Entry clears `cnt` to 0 and `falls` to 0.
  - In MEASURE, every cycle does `cnt <= cnt+1`. Each `fall` increments `falls`.
  - MEASURE → DONE on the `fall` that makes `falls == SYNC_FALLS`. On that same edge: `span <= cnt+1` and `brg_div <= (cnt+1) >> log2(2*SYNC_FALLS)`, with rounding per Configuration.
  - DONE → IDLE unconditionally. UxRXIF=1 for exactly the DONE cycle.
  - MEASURE → IDLE if `cnt` equals all-ones and no completing edge arrives in that cycle. This sets ABDOVF=1. `span` and `brg_div` stay unchanged and no UxRXIF pulse is generated.
  - WAIT_IDLE, WAIT_START or MEASURE → IDLE when ABAUD=0. Nothing is updated and no flags are raised.
- Arithmetic: `cnt+1` is computed CNT_W+1 wide before the shift. No wrap of `cnt` is permitted.
- ABAUD held high after DONE re-arms from IDLE on the following cycle. The firmware must drop ABAUD within one cycle of UxRXIF if a single measurement is wanted.
- Precedence in the same cycle, highest first: completing edge, then abort, then overflow. The edge also takes precedence over an overflow in the same cycle.

## Timing
- Reset values: state=IDLE, brg_div=RESET_DIV, span=0, abd_busy=0, UxRXIF=0, ABDOVF=0, synchroniser flops=1.
- rst_n assertion mid-measurement returns to IDLE immediately and asynchronously, with the reset values above.
- Latency from the UxRX edge to `fall` is 2–3 BRGCLK cycles. Both edges see the same delay, so `span` is exact to ±1 cycle.
- `span` equals the cycle distance between the start `fall` and the completing `fall`.
- UxRXIF is registered and asserts the cycle after the completing `fall`. `brg_div` and `span` are valid in that same cycle.
- abd_busy is a registered state decode. It deasserts in the DONE cycle.

## Configuration
- `UART_ABD_ROUND_EN` defined: `brg_div = ((cnt+1) + SYNC_FALLS) >> log2(2*SYNC_FALLS)`, which is round-to-nearest.
- Not defined: plain truncating shift.
- Neither setting changes any other behaviour.

## Test plan
- 0x55 at 16 cycles/bit, SYNC_FALLS=4, ABAUD=1 → span=128, brg_div=16, one UxRXIF pulse, ABDOVF=0.
- 0x55 at 13 cycles/bit, with a 1-cycle stretch on the last low bit to give span=105 → brg_div=13 with rounding enabled and 13 without. With span forced to 108 → 14 with rounding and 13 without.
- CNT_W=8, 0x55 at 40 cycles/bit → ABDOVF=1, brg_div keeps its prior value, no UxRXIF, state returns to IDLE.
- ABAUD dropped after the 2nd fall → IDLE next cycle, no UxRXIF, span and brg_div unchanged, ABDOVF=0.
- UxRX low when ABAUD rises, released high 50 cycles later, then 0x55 at 16 cycles/bit → measurement starts only at the subsequent start edge; span=128.
- rst_n pulsed low in MEASURE → all outputs at reset values asynchronously. After release, a 0x55 at 16 cycles/bit gives brg_div=16.
